// File: rtl/onescount_arbiter.sv
// onescount_arbiter: round-robin front end that time-shares one ones-count
// unit among N requesters, with a watchdog that aborts a job whose done pulse
// never arrives and reports it as an error response.
module onescount_arbiter #(
  parameter int N       = 4,
  parameter int W       = 30,
  parameter int CW      = $clog2(W + 1),
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     resp_valid,
  output logic [CW-1:0]    resp_count,
  output logic             resp_err,
  output logic             busy,
  output logic             oc_start,
  output logic [W-1:0]     oc_data,
  input  logic             oc_done,
  input  logic [CW-1:0]    oc_count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  ptr, owner, winner, cand;
  logic           found;
  logic [W-1:0]   data_q;
  logic [CW-1:0]  result;
  logic           err;
  logic [TW-1:0]  timer;

  // Rotating priority scan: first pending request at or above ptr, mod N.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (found) state_nx = START;
      START: state_nx = RUN;
      RUN:   if (oc_done || timer == TMAX) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  // Job registers: owner/operand latch, watchdog timer, result capture, pointer advance.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      ptr    <= '0;
      owner  <= '0;
      data_q <= '0;
      result <= '0;
      err    <= 1'b0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner  <= winner;
          data_q <= req_data[winner*W +: W];
        end
        START: timer <= '0;
        RUN: begin
          // done takes priority over the abort; timer stops at TMAX so it never wraps
          if (oc_done) begin
            result <= oc_count;
            err    <= 1'b0;
          end else if (timer == TMAX) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: ptr <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    ack        = '0;
    resp_valid = '0;
    if (state == START) ack[owner]        = 1'b1;
    if (state == RESP)  resp_valid[owner] = 1'b1;
    resp_count = (state == RESP) ? result : '0;
    resp_err   = (state == RESP) && err;
    busy       = (state != IDLE);
    oc_start   = (state == START);
    oc_data    = data_q;
  end

endmodule

// File: tb/tb_onescount_arbiter.sv
// tb_onescount_arbiter: directed and randomized jobs checked against a
// behavioural model of rotating-priority grant and job timing.
module tb_onescount_arbiter;

  localparam int N       = 4;
  localparam int W       = 30;
  localparam int CW      = $clog2(W + 1);
  localparam int TIMEOUT = 64;

  logic             clock = 1'b0;
  logic             reset_L;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     ack, resp_valid;
  logic [CW-1:0]    resp_count, oc_count;
  logic             resp_err, busy, oc_start, oc_done;
  logic [W-1:0]     oc_data;

  logic [W-1:0]     opnd [N];
  int               mptr;
  int               passed = 0;
  int               total  = 0;

  onescount_arbiter #(.N(N), .W(W), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_L(reset_L), .req(req), .req_data(req_data),
    .ack(ack), .resp_valid(resp_valid), .resp_count(resp_count),
    .resp_err(resp_err), .busy(busy), .oc_start(oc_start), .oc_data(oc_data),
    .oc_done(oc_done), .oc_count(oc_count)
  );

  always #5 clock = ~clock;

  // Pack the per-requester operand table onto the request bus.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = opnd[i];
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference rule: first pending requester scanning upward from the pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_ack"}, ack, '0);
    check({tag, "_resp_valid"}, resp_valid, '0);
    check({tag, "_resp_count"}, resp_count, '0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_oc_start"}, oc_start, 0);
  endtask

  // One complete job. lat = RUN cycles before the unit pulses done; hang = never.
  // The RUN phase may last at most TIMEOUT cycles before it is aborted.
  task automatic serve(input logic [N-1:0] rq, input logic [N-1:0] rq_after,
                       input int lat, input bit hang);
    int win, k, exp_k;
    bit exp_err;
    logic [N-1:0] oh;
    logic [W-1:0] op;
    win = pick(rq, mptr);
    op  = opnd[win];
    oh  = '0;
    oh[win] = 1'b1;
    req = rq;
    cyc();
    check("ack", ack, oh);
    check("oc_start", oc_start, 1);
    check("oc_data", oc_data, op);
    req = rq_after;
    exp_err = hang || (lat > TIMEOUT - 1);
    exp_k   = exp_err ? TIMEOUT + 1 : lat + 2;
    k = 0;
    while (k < TIMEOUT + 4) begin
      if (k >= 1 && !hang && k - 1 == lat) begin
        oc_done  = 1'b1;
        oc_count = CW'($countones(oc_data));
      end
      cyc();
      k++;
      oc_done = 1'b0;
      if (resp_valid != '0) break;
    end
    check("resp_valid", resp_valid, oh);
    check("resp_latency", k, exp_k);
    check("resp_count", resp_count, exp_err ? 0 : $countones(op));
    check("resp_err", resp_err, exp_err);
    check("oc_data_held", oc_data, op);
    mptr = (win + 1) % N;
    cyc();
    check("idle_busy", busy, 0);
    check("resp_one_cycle", resp_valid, '0);
    req = '0;
  endtask

  initial begin
    logic [N-1:0] seen;
    logic [N-1:0] rq;
    reset_L = 1'b0; req = '0; oc_done = 1'b0; oc_count = '0;
    for (int i = 0; i < N; i++) opnd[i] = '0;
    mptr = 0;

    // reset state
    cyc(); cyc();
    check_quiet("reset");
    check("reset_oc_data", oc_data, '0);
    reset_L = 1'b1;
    cyc();

    // single job, all-ones operand
    opnd[0] = 30'h3FFF_FFFF;
    serve(4'b0001, 4'b0000, 3, 1'b0);

    // round robin from ptr=0 with all requests held
    reset_L = 1'b0; cyc(); reset_L = 1'b1; cyc(); mptr = 0;
    opnd[0] = 30'd0; opnd[1] = 30'd1; opnd[2] = 30'd3; opnd[3] = 30'd7;
    for (int j = 0; j < 5; j++) begin
      check("rr_order", pick(4'b1111, mptr), j % N);
      serve(4'b1111, 4'b1111, j + 1, 1'b0);
    end

    // watchdog abort, then done colliding with the last RUN cycle
    opnd[0] = 30'h0000_FFFF;
    serve(4'b0001, 4'b0000, 0, 1'b1);
    opnd[1] = 30'h0000_001F;
    serve(4'b0010, 4'b0000, TIMEOUT - 1, 1'b0);
    check("collision_count_value", $countones(opnd[1]), 5);

    // reset mid-RUN; pointer is 2 before the aborted job
    serve(4'b0010, 4'b0000, 1, 1'b0);
    req = 4'b1000;
    cyc();
    check("midrun_ack", ack, 4'b1000);
    req = '0;
    cyc(); cyc();
    check("midrun_busy", busy, 1);
    reset_L = 1'b0;
    cyc();
    check_quiet("midrun_reset");
    check("midrun_oc_data", oc_data, '0);
    reset_L = 1'b1;
    seen = '0;
    for (int i = 0; i < 4; i++) begin cyc(); seen |= resp_valid; end
    check("midrun_no_resp", seen, '0);
    mptr = 0;
    opnd[0] = 30'h2AAA_AAAA; opnd[2] = 30'h0000_0101;
    serve(4'b0101, 4'b0000, 2, 1'b0);
    serve(4'b0100, 4'b0000, 0, 1'b0);

    // stray done in IDLE, then req[2] dropped right after sampling
    oc_done = 1'b1; oc_count = 5'd9;
    cyc();
    oc_done = 1'b0;
    seen = '0;
    for (int i = 0; i < 3; i++) begin cyc(); seen |= resp_valid | {N{busy}}; end
    check("stray_done_ignored", seen, '0);
    opnd[2] = 30'h1234_5678;
    serve(4'b0100, 4'b0000, 4, 1'b0);

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++) opnd[i] = W'($urandom);
      rq = N'($urandom_range(1, (1 << N) - 1));
      serve(rq, N'($urandom), $urandom_range(0, TIMEOUT + 2), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
